// File: rtl/arith_op_scheduler_if.sv
// Request/result bundle between client blocks and arith_op_scheduler.
// master: client side (drives requests), slave: scheduler side (drives results).
interface arith_op_scheduler_if;
    logic [1:0] req;
    logic [2:0] op0;
    logic [2:0] op1;
    logic [7:0] num0;
    logic [7:0] num1;
    logic [1:0] ack;
    logic [7:0] res;
    logic       res_valid;
    logic       res_id;
    logic       err;
    logic       busy;

    modport master (
        output req, op0, op1, num0, num1,
        input  ack, res, res_valid, res_id, err, busy
    );

    modport slave (
        input  req, op0, op1, num0, num1,
        output ack, res, res_valid, res_id, err, busy
    );
endinterface

// File: rtl/arith_op_scheduler.sv
// Shares one constant-coefficient arithmetic unit (add/sub/mul/div/mod by COEF)
// between two round-robin arbitrated requesters.
// Optional build macro ARITH_SCHED_STATS_EN adds per-requester completion counters.
//
// state | meaning
// IDLE  | waiting for a request; no grant in the cycle the previous result is shown
// EXEC  | one cycle for add/sub/mul/errors, eight restoring-divide steps (7..0) for div/mod
// DONE  | result registered out next edge; rr pointer moves to the other requester
module arith_op_scheduler #(
    parameter logic [7:0] COEF = 8'h02
) (
    input  logic                 clk,
    input  logic                 rst_n,
    arith_op_scheduler_if.slave  bus
`ifdef ARITH_SCHED_STATS_EN
    ,
    output logic [15:0]          done_cnt0,
    output logic [15:0]          done_cnt1
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t     state_q, state_d;
    logic       ptr_q, id_q, err_q;
    logic [2:0] op_q, step_q;
    logic [7:0] num_q, acc_q, rem_q, dvd_q;
    logic       valid_q, res_id_q, err_out_q;
    logic [1:0] ack_q;
    logic [7:0] res_q;
    logic       grant, gnt_id, div_step, div_ok;
    logic [8:0] trial;
    logic       q_bit;
    logic [7:0] rem_nx, result;

    // Divider runs only for a legal div/mod with a non-zero coefficient.
    assign div_ok = ((op_q == 3'd3) || (op_q == 3'd4)) && (COEF != 8'h00);
    assign trial  = {rem_q, dvd_q[7]};
    assign q_bit  = (trial >= {1'b0, COEF});
    assign rem_nx = q_bit ? 8'(trial - {1'b0, COEF}) : trial[7:0];
    assign result = div_ok ? ((op_q == 3'd3) ? dvd_q : rem_q) : acc_q;

    // Next-state, arbitration and divider-step control.
    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        gnt_id   = ptr_q;
        div_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!valid_q && (bus.req != 2'b00)) begin
                    grant   = 1'b1;
                    gnt_id  = bus.req[ptr_q] ? ptr_q : ~ptr_q;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (div_ok) begin
                    div_step = 1'b1;
                    if (step_q == 3'd0) state_d = S_DONE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Operand latch on grant, then single-cycle compute or one divide step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q   <= 1'b0;
            op_q   <= 3'd0;
            num_q  <= 8'h00;
            acc_q  <= 8'h00;
            err_q  <= 1'b0;
            rem_q  <= 8'h00;
            dvd_q  <= 8'h00;
            step_q <= 3'd0;
        end else if (grant) begin
            id_q   <= gnt_id;
            op_q   <= gnt_id ? bus.op1 : bus.op0;
            num_q  <= gnt_id ? bus.num1 : bus.num0;
            dvd_q  <= gnt_id ? bus.num1 : bus.num0;
            rem_q  <= 8'h00;
            acc_q  <= 8'h00;
            err_q  <= 1'b0;
            step_q <= 3'd7;
        end else if (div_step) begin
            rem_q  <= rem_nx;
            dvd_q  <= {dvd_q[6:0], q_bit};
            step_q <= step_q - 3'd1;
        end else if (state_q == S_EXEC) begin
            case (op_q)
                3'd0: acc_q <= num_q + COEF;
                3'd1: acc_q <= num_q - COEF;
                3'd2: acc_q <= num_q * COEF;
                3'd3: begin acc_q <= 8'hFF; err_q <= 1'b1; end
                3'd4: begin acc_q <= num_q; err_q <= 1'b1; end
                default: begin acc_q <= 8'h00; err_q <= 1'b1; end
            endcase
        end
    end

    // Registered result strobe, ack pulse and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ack_q     <= 2'b00;
            res_q     <= 8'h00;
            err_out_q <= 1'b0;
            res_id_q  <= 1'b0;
            ptr_q     <= 1'b0;
        end else begin
            valid_q   <= (state_q == S_DONE);
            ack_q     <= (state_q == S_DONE) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
            res_q     <= (state_q == S_DONE) ? result : 8'h00;
            err_out_q <= (state_q == S_DONE) ? err_q : 1'b0;
            res_id_q  <= (state_q == S_DONE) ? id_q : 1'b0;
            if (state_q == S_DONE) ptr_q <= ~id_q;
        end
    end

`ifdef ARITH_SCHED_STATS_EN
    // Saturating completed-op counters per requester, error ops included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt0 <= 16'h0000;
            done_cnt1 <= 16'h0000;
        end else if (state_q == S_DONE) begin
            if (!id_q && (done_cnt0 != 16'hFFFF)) done_cnt0 <= done_cnt0 + 16'd1;
            if (id_q && (done_cnt1 != 16'hFFFF))  done_cnt1 <= done_cnt1 + 16'd1;
        end
    end
`endif

    assign bus.ack       = ack_q;
    assign bus.res       = res_q;
    assign bus.res_valid = valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.err       = err_out_q;
    assign bus.busy      = (state_q == S_EXEC) || (state_q == S_DONE);
endmodule
